iomem_synth_regs: RTL and testbench

//  Parametrised iomem slave; successor to the fixed single-channel freq/gpio register pair.

---
 rtl/iomem_synth_regs_pkg.sv | 38 +++
 rtl/iomem_synth_regs_fifo.sv | 67 ++++++
 rtl/iomem_synth_regs.sv | 170 +++++++++++++++++
 tb/tb_iomem_synth_regs.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_synth_regs_pkg.sv
// Register map constants and strobe helpers for the synth iomem slave.
// Shared between the register block and anything that talks to it.
package iomem_synth_regs_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_FIFO   = 8'h08;
  localparam logic [7:0] OFF_FREQ0  = 8'h10;

  localparam logic [5:0] WD_CTRL   = OFF_CTRL[7:2];
  localparam logic [5:0] WD_STATUS = OFF_STATUS[7:2];
  localparam logic [5:0] WD_FIFO   = OFF_FIFO[7:2];
  localparam logic [5:0] WD_FREQ0  = OFF_FREQ0[7:2];

  localparam int CT_SE    = 8;
  localparam int CT_TH    = 16;
  localparam int ST_FULL  = 12;
  localparam int ST_EMPTY = 13;
  localparam int ST_UNDER = 16;
  localparam int ST_OVER  = 17;

  function automatic logic [31:0] strb_mask(
    input logic [3:0] s
  );
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  s
  );
    logic [31:0] m;
    m = strb_mask(s);
    return (old_v & ~m) | (new_v & m);
  endfunction

endpackage

// File: rtl/iomem_synth_regs_fifo.sv
// Sample FIFO with a registered read head; a pop on empty yields zero.
// Push while full is only taken when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_level,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic [WIDTH-1:0] r_rdata;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_rdata;
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | i_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush)
      r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_rdata <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_rdata <= '0;
    end else begin
      if (w_do_push)
        r_wptr <= r_wptr + AW'(1);
      if (i_pop)
        r_rdata <= o_empty ? '0 : r_mem[r_rptr];
      if (w_do_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/iomem_synth_regs.sv
// picosoc iomem slave: oscillator freq/enable registers, DACLRC-drained
// sample FIFO for i2s streaming, sticky error flags and low-water IRQ.
module iomem_synth_regs
  import iomem_synth_regs_pkg::*;
#(
  parameter int         NUM_CH     = 4,
  parameter int         PHASE_SIZE = 32,
  parameter int         BITSIZE    = 16,
  parameter int         FIFO_AW    = 4,
  parameter logic [7:0] BASE       = 8'h04
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           iomem_valid,
  output logic                           iomem_ready,
  input  logic [3:0]                     iomem_wstrb,
  input  logic [31:0]                    iomem_addr,
  input  logic [31:0]                    iomem_wdata,
  output logic [31:0]                    iomem_rdata,
  input  logic                           lrclk,
  output logic [NUM_CH*PHASE_SIZE-1:0]   freq_flat,
  output logic [NUM_CH-1:0]              ch_enable,
  output logic                           stream_en,
  output logic [BITSIZE-1:0]             stream_sample,
  output logic                           irq
);

  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic [NUM_CH-1:0]     r_ch_en;
  logic                  r_se;
  logic [7:0]            r_thresh;
  logic [PHASE_SIZE-1:0] r_freq [NUM_CH];
  logic [2:0]            r_sync;
  logic                  r_rise;
  logic                  r_under;
  logic                  r_over;
  logic                  r_irq;

  logic                  w_hit;
  logic                  w_wr;
  logic [5:0]            w_word;
  logic                  w_ctrl_wr;
  logic                  w_st_wr;
  logic                  w_se_nxt;
  logic                  w_flush;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_clr_u;
  logic                  w_clr_o;
  logic [31:0]           w_rd;
  logic [BITSIZE-1:0]    w_head;
  logic [FIFO_AW:0]      w_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_unused;

  assign w_hit  = iomem_valid & ~r_ready & (iomem_addr[31:24] == BASE);
  assign w_wr   = w_hit & (|iomem_wstrb);
  assign w_word = iomem_addr[7:2];

  assign w_ctrl_wr = w_wr & (w_word == WD_CTRL);
  assign w_st_wr   = w_wr & (w_word == WD_STATUS) & iomem_wstrb[2];
  assign w_push    = w_wr & (w_word == WD_FIFO);
  assign w_pop     = r_rise & r_se;
  assign w_clr_u   = w_st_wr & iomem_wdata[ST_UNDER];
  assign w_clr_o   = w_st_wr & iomem_wdata[ST_OVER];

  // Leaving streaming mode discards everything queued.
  assign w_se_nxt = (w_ctrl_wr & iomem_wstrb[1]) ? iomem_wdata[CT_SE] : r_se;
  assign w_flush  = r_se & ~w_se_nxt;

  assign w_unused = ^{iomem_addr[23:8], iomem_addr[1:0]};

  sync_fifo #(
    .WIDTH (BITSIZE),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (iomem_wdata[BITSIZE-1:0]),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_rd = '0;
    case (w_word)
      WD_CTRL: begin
        w_rd[NUM_CH-1:0]  = r_ch_en;
        w_rd[CT_SE]       = r_se;
        w_rd[CT_TH +: 8]  = r_thresh;
      end
      WD_STATUS: begin
        w_rd[FIFO_AW:0]   = w_level;
        w_rd[ST_FULL]     = w_full;
        w_rd[ST_EMPTY]    = w_empty;
        w_rd[ST_UNDER]    = r_under;
        w_rd[ST_OVER]     = r_over;
      end
      default: w_rd = '0;
    endcase
    for (int i = 0; i < NUM_CH; i++)
      if (w_word == WD_FREQ0 + 6'(i))
        w_rd = 32'(r_freq[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_ch_en  <= '0;
      r_se     <= 1'b0;
      r_thresh <= '0;
      r_sync   <= '0;
      r_rise   <= 1'b0;
      r_under  <= 1'b0;
      r_over   <= 1'b0;
      r_irq    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        r_freq[i] <= '0;
    end else begin
      r_ready <= w_hit;
      if (w_hit)
        r_rdata <= w_rd;
      // [0],[1] synchronise; [2] is the previous synchronised level.
      r_sync <= {r_sync[1:0], lrclk};
      r_rise <= r_sync[1] & ~r_sync[2];
      if (w_ctrl_wr) begin
        if (iomem_wstrb[0])
          r_ch_en <= iomem_wdata[NUM_CH-1:0];
        if (iomem_wstrb[1])
          r_se <= iomem_wdata[CT_SE];
        if (iomem_wstrb[2])
          r_thresh <= iomem_wdata[CT_TH +: 8];
      end
      for (int i = 0; i < NUM_CH; i++)
        if (w_wr && (w_word == WD_FREQ0 + 6'(i)))
          r_freq[i] <= PHASE_SIZE'(strb_merge(32'(r_freq[i]),
                                              iomem_wdata,
                                              iomem_wstrb));
      if (w_pop && w_empty)
        r_under <= 1'b1;
      else if (w_clr_u)
        r_under <= 1'b0;
      if (w_push && w_full && !w_pop)
        r_over <= 1'b1;
      else if (w_clr_o)
        r_over <= 1'b0;
      r_irq <= r_se & (32'(w_level) <= 32'(r_thresh));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_freq
    assign freq_flat[g*PHASE_SIZE +: PHASE_SIZE] = r_freq[g];
  end

  assign iomem_ready   = r_ready;
  assign iomem_rdata   = r_rdata;
  assign ch_enable     = r_ch_en;
  assign stream_en     = r_se;
  assign stream_sample = w_head;
  assign irq           = r_irq;

endmodule

// File: tb/tb_iomem_synth_regs.sv
// Randomised bench for iomem_synth_regs against a queue-based model
// of the register map, FIFO streaming, sticky flags and IRQ.
module tb_iomem_synth_regs;
  import iomem_synth_regs_pkg::*;

  logic         clk = 0;
  logic         reset = 1;
  logic         iomem_valid = 0;
  logic         iomem_ready;
  logic [3:0]   iomem_wstrb = 0;
  logic [31:0]  iomem_addr = 0;
  logic [31:0]  iomem_wdata = 0;
  logic [31:0]  iomem_rdata;
  logic         lrclk = 0;
  logic [127:0] freq_flat;
  logic [3:0]   ch_enable;
  logic         stream_en;
  logic [15:0]  stream_sample;
  logic         irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_freq [4];
  logic [3:0]  m_ch;
  logic        m_se;
  logic [7:0]  m_th;
  logic [15:0] m_q [$];
  logic [15:0] m_sample;
  logic        m_under;
  logic        m_over;

  localparam logic [31:0] A_BASE = 32'h0400_0000;

  iomem_synth_regs dut (
    .clk           (clk),
    .reset         (reset),
    .iomem_valid   (iomem_valid),
    .iomem_ready   (iomem_ready),
    .iomem_wstrb   (iomem_wstrb),
    .iomem_addr    (iomem_addr),
    .iomem_wdata   (iomem_wdata),
    .iomem_rdata   (iomem_rdata),
    .lrclk         (lrclk),
    .freq_flat     (freq_flat),
    .ch_enable     (ch_enable),
    .stream_en     (stream_en),
    .stream_sample (stream_sample),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_freq[i] = 0;
    m_ch = 0; m_se = 0; m_th = 0;
    m_q.delete();
    m_sample = 0; m_under = 0; m_over = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    logic [7:0]  o;
    v = 0;
    o = a[7:0];
    if (o == OFF_CTRL)
      v = {8'h0, m_th, 7'h0, m_se, 4'h0, m_ch};
    else if (o == OFF_STATUS) begin
      v[4:0] = 5'(m_q.size());
      v[12]  = (m_q.size() == 16);
      v[13]  = (m_q.size() == 0);
      v[16]  = m_under;
      v[17]  = m_over;
    end else if (o >= 8'h10 && o <= 8'h1C && o[1:0] == 0)
      v = m_freq[(o - 8'h10) >> 2];
    return v;
  endfunction

  // One bus transaction; returns at the negedge where ready is seen.
  task automatic bus(input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r);
    int n;
    iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    iomem_valid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iomem_ready && n < 20);
    if (!iomem_ready) chk("bus_timeout", 0, 1);
    r = iomem_rdata;
    iomem_valid = 0;
    iomem_wstrb = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d);
    logic [31:0] r;
    logic [7:0]  o;
    logic [31:0] m;
    bus(a, s, d, r);
    o = a[7:0];
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (o == OFF_CTRL) begin
      if (s[0]) m_ch = d[3:0];
      if (s[1]) begin
        if (m_se && !d[8]) begin
          m_q.delete();
          m_sample = 0;
        end
        m_se = d[8];
      end
      if (s[2]) m_th = d[23:16];
    end else if (o == OFF_STATUS) begin
      if (s[2] && d[16]) m_under = 0;
      if (s[2] && d[17]) m_over = 0;
    end else if (o == OFF_FIFO) begin
      if (m_q.size() == 16) m_over = 1;
      else m_q.push_back(d[15:0]);
    end else if (o >= 8'h10 && o <= 8'h1C && o[1:0] == 0) begin
      m_freq[(o - 8'h10) >> 2] = (m_freq[(o - 8'h10) >> 2] & ~m) | (d & m);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    logic [31:0] r;
    bus(a, 4'h0, $urandom, r);
    chk(tag, r, m_read(a));
  endtask

  task automatic m_pop();
    if (m_se) begin
      if (m_q.size() == 0) begin
        m_sample = 0;
        m_under = 1;
      end else
        m_sample = m_q.pop_front();
    end
  endtask

  task automatic lr();
    lrclk = 1;
    repeat (8) @(negedge clk);
    lrclk = 0;
    repeat (4) @(negedge clk);
    m_pop();
    chk("sample", stream_sample, m_sample);
  endtask

  task automatic chk_out();
    repeat (2) @(negedge clk);
    chk("irq", irq, m_se && (m_q.size() <= m_th));
    chk("ch_enable", ch_enable, m_ch);
    chk("stream_en", stream_en, m_se);
    chk("stream_sample", stream_sample, m_sample);
  endtask

  task automatic chk_freq();
    for (int i = 0; i < 4; i++)
      chk("freq_flat", freq_flat[i*32 +: 32], m_freq[i]);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] d;
    logic [31:0] hold;
    logic        seen;
    int          op;

    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", iomem_ready, 0);
    chk("rst_irq", irq, 0);
    chk("rst_sample", stream_sample, 0);
    chk_freq();
    reset = 0;
    @(negedge clk);
    rd("rst_status", A_BASE + OFF_STATUS);
    rd("rst_ctrl", A_BASE + OFF_CTRL);

    // Single-byte freq write and ready pulse width.
    wr(A_BASE + 32'h10, 4'b0100, 32'h0001_0000);
    chk("ready_hi", iomem_ready, 1);
    @(negedge clk);
    chk("ready_lo", iomem_ready, 0);
    rd("freq0", A_BASE + 32'h10);

    for (int k = 0; k < 12; k++)
      wr(A_BASE + OFF_FREQ0 + 32'($urandom_range(0, 3) * 4),
         4'($urandom_range(1, 15)), $urandom);
    for (int i = 0; i < 4; i++)
      rd("freq_rb", A_BASE + OFF_FREQ0 + 32'(i * 4));
    rd("freq3", A_BASE + 32'h1C);
    chk_freq();
    rd("unmapped40", A_BASE + 32'h40);
    rd("unmapped0c", A_BASE + 32'h0C);
    wr(A_BASE + 32'h0C, 4'hF, 32'hFFFF_FFFF);
    rd("fifo_rd0", A_BASE + OFF_FIFO);

    // Other base: never acknowledged, rdata holds.
    hold = iomem_rdata;
    iomem_addr = 32'h0500_0010; iomem_wstrb = 4'hF;
    iomem_wdata = 32'hDEAD_BEEF; iomem_valid = 1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen |= iomem_ready;
    end
    iomem_valid = 0; iomem_wstrb = 0;
    chk("miss_ready", seen, 0);
    chk("miss_rdata", iomem_rdata, hold);
    chk_freq();

    // Streaming with low-water threshold 2.
    wr(A_BASE + OFF_CTRL, 4'b0111, {8'h0, 8'd2, 7'h0, 1'b1, 4'h0, 4'($urandom)});
    rd("ctrl", A_BASE + OFF_CTRL);
    wr(A_BASE + OFF_FIFO, 4'hF, 32'h1111);
    wr(A_BASE + OFF_FIFO, 4'hF, 32'h2222);
    wr(A_BASE + OFF_FIFO, 4'h3, 32'h3333);
    rd("status3", A_BASE + OFF_STATUS);
    chk_out();
    for (int k = 0; k < 3; k++) begin
      lr();
      chk_out();
    end
    chk("last_sample", stream_sample, 16'h3333);

    // Underrun and its write-1-to-clear.
    lr();
    rd("underrun", A_BASE + OFF_STATUS);
    wr(A_BASE + OFF_STATUS, 4'b0100, 32'h0001_0000);
    rd("under_clr", A_BASE + OFF_STATUS);

    // Overfill: the 17th word is dropped.
    for (int k = 0; k < 17; k++)
      wr(A_BASE + OFF_FIFO, 4'hF, $urandom);
    rd("full", A_BASE + OFF_STATUS);
    chk_out();
    wr(A_BASE + OFF_STATUS, 4'b0100, 32'h0002_0000);
    rd("over_clr", A_BASE + OFF_STATUS);

    // Push lands on the same edge as the pop while full.
    lrclk = 1;
    repeat (3) @(negedge clk);
    d = $urandom;
    bus(A_BASE + OFF_FIFO, 4'hF, d, r);
    m_pop();
    m_q.push_back(d[15:0]);
    repeat (6) @(negedge clk);
    lrclk = 0;
    repeat (4) @(negedge clk);
    chk("same_sample", stream_sample, m_sample);
    rd("same_status", A_BASE + OFF_STATUS);
    for (int k = 0; k < 16; k++)
      lr();
    rd("drained", A_BASE + OFF_STATUS);

    // Random mix of bus traffic and DACLRC edges.
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 6);
      if (op <= 1)
        wr(A_BASE + OFF_FIFO, 4'($urandom_range(1, 15)), $urandom);
      else if (op <= 3)
        lr();
      else if (op == 4)
        rd("rnd_status", A_BASE + OFF_STATUS);
      else if (op == 5)
        wr(A_BASE + OFF_CTRL, 4'b0111,
           {8'h0, 8'($urandom_range(0, 18)), 7'h0,
            1'($urandom_range(0, 4) != 0), 4'($urandom)});
      else
        wr(A_BASE + OFF_STATUS, 4'b0100, $urandom);
      chk_out();
    end
    rd("rnd_end", A_BASE + OFF_STATUS);

    // Reset in the middle of a transaction.
    wr(A_BASE + OFF_CTRL, 4'b0111, {8'h0, 8'hFF, 7'h0, 1'b1, 4'hF});
    wr(A_BASE + 32'h14, 4'hF, 32'h1234_5678);
    chk_out();
    iomem_addr = A_BASE + 32'h18; iomem_wstrb = 4'hF;
    iomem_wdata = 32'hCAFE_0001; iomem_valid = 1;
    @(posedge clk);
    #1;
    chk("pre_rst_ready", iomem_ready, 1);
    reset = 1;
    #1;
    m_reset();
    chk("mid_rst_ready", iomem_ready, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_se", stream_en, 0);
    chk_freq();
    iomem_valid = 0; iomem_wstrb = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    rd("post_rst_status", A_BASE + OFF_STATUS);
    rd("post_rst_freq2", A_BASE + 32'h18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
